// File: rtl/gsr_pkg.sv
// Shared definitions for the global set/reset generator: state encodings,
// default parameter values and a small helper for sizing the counter.
package gsr_pkg;

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_FILTER = 2'd1,
      ST_HOLD   = 2'd2,
      ST_RUN    = 2'd3
   } gsr_state_t;

   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_FILTER_CYCLES = 4;
   localparam int DEF_HOLD_CYCLES   = 16;

   // Larger of two integers, used in constant expressions for counter sizing.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/gsr_sync.sv
// N-stage synchronizer with asynchronous active-low clear to 0.
// Used both to release the board reset cleanly and to bring GSRI into
// the I_clk domain.
module gsr_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic clr_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // Shift the input through the chain; clearing is immediate, release is clocked.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/gsr.sv
// Global set/reset generator. Merges the board reset with the GSRI request,
// filters GSRI, stretches the reset and releases it synchronously to I_clk.
// Assertion via I_rst_n is asynchronous; GSRI assertion goes through the
// synchronizer so the output is never combinationally derived from GSRI.
module gsr
   import gsr_pkg::*;
#(
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
   input  logic       I_clk,
   input  logic       I_rst_n,
   input  logic       GSRI,
   output logic       O_gsr_n,
   output logic       O_gsr,
   output logic       O_release,
   output logic [1:0] O_state,
   output logic [7:0] O_gsr_cnt
);

   localparam int CNT_W = $clog2(max_int(FILTER_CYCLES, HOLD_CYCLES)) + 1;
   localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(FILTER_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

   logic             rst_sync_n;
   logic             gsri_sync;
   gsr_state_t       state;
   gsr_state_t       next_state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] next_cnt;
   logic             gsr_inc;
   logic             gsr_n_q;
   logic             release_q;
   logic [7:0]       gsr_cnt_q;

   gsr_sync #(.STAGES(SYNC_STAGES)) u_rst_sync (
      .clk   (I_clk),
      .clr_n (I_rst_n),
      .d     (1'b1),
      .q     (rst_sync_n)
   );

   gsr_sync #(.STAGES(SYNC_STAGES)) u_gsri_sync (
      .clk   (I_clk),
      .clr_n (I_rst_n),
      .d     (GSRI),
      .q     (gsri_sync)
   );

   // Next-state logic: filter GSRI high, then hold, then run; any low GSRI restarts.
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      gsr_inc    = 1'b0;
      case (state)
         ST_RESET: begin
            next_cnt = '0;
            if (rst_sync_n && gsri_sync) begin
               next_state = ST_FILTER;
               next_cnt   = CNT_W'(1);
            end
         end
         ST_FILTER: begin
            if (!gsri_sync) begin
               next_state = ST_RESET;
               next_cnt   = '0;
            end else if (cnt == FILTER_LAST) begin
               next_state = ST_HOLD;
               next_cnt   = '0;
            end else begin
               next_cnt = cnt + CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (!gsri_sync) begin
               next_state = ST_RESET;
               next_cnt   = '0;
            end else if (cnt == HOLD_LAST) begin
               next_state = ST_RUN;
               next_cnt   = '0;
            end else begin
               next_cnt = cnt + CNT_W'(1);
            end
         end
         ST_RUN: begin
            next_cnt = '0;
            if (!gsri_sync) begin
               next_state = ST_RESET;
               gsr_inc    = 1'b1;
            end
         end
         default: begin
            next_state = ST_RESET;
            next_cnt   = '0;
         end
      endcase
   end

   // State, counter and registered outputs; the board reset clears everything at once.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state     <= ST_RESET;
         cnt       <= '0;
         gsr_n_q   <= 1'b0;
         release_q <= 1'b0;
         gsr_cnt_q <= 8'd0;
      end else begin
         state     <= next_state;
         cnt       <= next_cnt;
         gsr_n_q   <= (next_state == ST_RUN);
         release_q <= (next_state == ST_RUN) && (state != ST_RUN);
         if (gsr_inc && (gsr_cnt_q != 8'hFF)) begin
            gsr_cnt_q <= gsr_cnt_q + 8'd1;
         end
      end
   end

   assign O_gsr_n   = gsr_n_q;
   assign O_gsr     = ~gsr_n_q;
   assign O_release = release_q;
   assign O_state   = state;
   assign O_gsr_cnt = gsr_cnt_q;

endmodule

// File: tb/tb_gsr.sv
// Directed testbench for the global set/reset generator with default parameters.
module tb_gsr;

   logic       clk;
   logic       rst_n;
   logic       gsri;
   logic       gsr_n;
   logic       gsr;
   logic       rel;
   logic [1:0] state;
   logic [7:0] gsr_cnt;

   int num_checks = 0;
   int num_fails  = 0;

   gsr dut (
      .I_clk     (clk),
      .I_rst_n   (rst_n),
      .GSRI      (gsri),
      .O_gsr_n   (gsr_n),
      .O_gsr     (gsr),
      .O_release (rel),
      .O_state   (state),
      .O_gsr_cnt (gsr_cnt)
   );

   // Free-running clock, 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      num_checks++;
      if (observed !== expected) begin
         num_fails++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Advance one active edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Walk the 23-edge release from the first edge after GSRI/reset went high.
   task automatic applyStimulus(input string tag);
      logic [1:0] exp_state;
      for (int e = 1; e <= 24; e++) begin
         tick();
         if (e < 3)       exp_state = 2'd0;
         else if (e < 7)  exp_state = 2'd1;
         else if (e < 23) exp_state = 2'd2;
         else             exp_state = 2'd3;
         checkOutput($sformatf("%s_state_e%0d", tag, e), 32'(state), 32'(exp_state));
         checkOutput($sformatf("%s_gsr_n_e%0d", tag, e), 32'(gsr_n), (e >= 23) ? 32'd1 : 32'd0);
         checkOutput($sformatf("%s_rel_e%0d", tag, e), 32'(rel), (e == 23) ? 32'd1 : 32'd0);
         checkOutput($sformatf("%s_gsr_e%0d", tag, e), 32'(gsr), (e >= 23) ? 32'd0 : 32'd1);
      end
   endtask

   initial begin
      int rise_edge;
      int transitions;
      int pulses;
      logic prev_gsr_n;

      rst_n = 1'b0;
      gsri  = 1'b1;
      #2;
      checkOutput("rst_gsr_n", 32'(gsr_n), 32'd0);
      checkOutput("rst_gsr", 32'(gsr), 32'd1);
      checkOutput("rst_rel", 32'(rel), 32'd0);
      checkOutput("rst_state", 32'(state), 32'd0);
      checkOutput("rst_cnt", 32'(gsr_cnt), 32'd0);

      // Power-on release
      tick();
      tick();
      rst_n = 1'b1;
      applyStimulus("t1");
      checkOutput("t1_cnt", 32'(gsr_cnt), 32'd0);

      // GSRI low for 5 clocks while running
      gsri = 1'b0;
      tick();
      checkOutput("t2_gsr_n_e1", 32'(gsr_n), 32'd1);
      tick();
      checkOutput("t2_gsr_n_e2", 32'(gsr_n), 32'd1);
      checkOutput("t2_cnt_e2", 32'(gsr_cnt), 32'd0);
      tick();
      checkOutput("t2_gsr_n_e3", 32'(gsr_n), 32'd0);
      checkOutput("t2_state_e3", 32'(state), 32'd0);
      checkOutput("t2_cnt_e3", 32'(gsr_cnt), 32'd1);
      tick();
      tick();
      gsri = 1'b1;
      applyStimulus("t2");
      checkOutput("t2_cnt_end", 32'(gsr_cnt), 32'd1);

      // GSRI glitch while filtering
      gsri = 1'b0;
      repeat (5) tick();
      checkOutput("t3_pre_state", 32'(state), 32'd0);
      checkOutput("t3_pre_cnt", 32'(gsr_cnt), 32'd2);
      gsri = 1'b1;
      repeat (4) tick();
      checkOutput("t3_in_filter", 32'(state), 32'd1);
      gsri = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         checkOutput($sformatf("t3_glitch_gsr_n_%0d", i), 32'(gsr_n), 32'd0);
      end
      checkOutput("t3_back_reset", 32'(state), 32'd0);
      gsri = 1'b1;
      applyStimulus("t3");
      checkOutput("t3_cnt_end", 32'(gsr_cnt), 32'd2);

      // Asynchronous board reset mid-clock while running
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("t4_gsr_n", 32'(gsr_n), 32'd0);
      checkOutput("t4_gsr", 32'(gsr), 32'd1);
      checkOutput("t4_state", 32'(state), 32'd0);
      checkOutput("t4_cnt", 32'(gsr_cnt), 32'd0);
      tick();
      rst_n = 1'b1;
      applyStimulus("t4");

      // 300 GSRI events saturate the event counter
      for (int i = 1; i <= 300; i++) begin
         gsri = 1'b0;
         repeat (3) tick();
         gsri = 1'b1;
         repeat (23) tick();
         if (i == 1)   checkOutput("t5_cnt_1", 32'(gsr_cnt), 32'd1);
         if (i == 254) checkOutput("t5_cnt_254", 32'(gsr_cnt), 32'd254);
         if (i == 255) checkOutput("t5_cnt_255", 32'(gsr_cnt), 32'd255);
      end
      checkOutput("t5_cnt_300", 32'(gsr_cnt), 32'd255);
      checkOutput("t5_state", 32'(state), 32'd3);
      checkOutput("t5_gsr_n", 32'(gsr_n), 32'd1);

      // Reset released while GSRI is held low: stay in reset
      rst_n = 1'b0;
      gsri  = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (30) tick();
      checkOutput("t6_stuck_state", 32'(state), 32'd0);
      checkOutput("t6_stuck_gsr_n", 32'(gsr_n), 32'd0);
      checkOutput("t6_stuck_cnt", 32'(gsr_cnt), 32'd0);
      gsri = 1'b1;
      applyStimulus("t6");

      // GSRI tied high for 17500 clocks after a fresh reset: a single release
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      rise_edge   = 0;
      transitions = 0;
      pulses      = 0;
      prev_gsr_n  = gsr_n;
      for (int e = 1; e <= 17500; e++) begin
         tick();
         if (gsr_n !== prev_gsr_n) begin
            transitions++;
            if (rise_edge == 0) rise_edge = e;
         end
         if (rel === 1'b1) pulses++;
         prev_gsr_n = gsr_n;
      end
      checkOutput("t7_rise_edge", 32'(rise_edge), 32'd23);
      checkOutput("t7_transitions", 32'(transitions), 32'd1);
      checkOutput("t7_pulses", 32'(pulses), 32'd1);
      checkOutput("t7_gsr_n", 32'(gsr_n), 32'd1);
      checkOutput("t7_cnt", 32'(gsr_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
      $finish;
   end

endmodule

// File: doc/gsr.md
# gsr

Global set/reset generator for the design. It merges the board reset (I_rst_n) with the active-low global reset request GSRI. It then drives a clean, glitch-filtered, stretched reset that every downstream core uses, for example the SPDIF transmitter. Assertion is fast; release is always synchronous to I_clk.

## Interface
- SYNC_STAGES, 2: synchronizer depth (≥2) for the I_rst_n release and for GSRI.
- FILTER_CYCLES, 4: consecutive clocks GSRI must be seen high before release proceeds (≥1).
- HOLD_CYCLES, 16: extra clocks reset is held after filtering (≥1).
- I_clk  in  1  system clock.
- I_rst_n  in  1  Asynchronous, active-low reset.
- GSRI  in  1  Global set/reset request, active-low, asynchronous to I_clk. Tie 1'b1 when unused.
- O_gsr_n  out  1  Global reset, active-low; 1 = design running.
- O_gsr  out  1  Inverse of O_gsr_n.
- O_release  out  1  One-clock pulse on the edge O_gsr_n rises.
- O_state  out  2  FSM state: 0 RESET, 1 FILTER, 2 HOLD, 3 RUN.
- O_gsr_cnt  out  8  Count of GSRI-initiated resets, saturating at 255.

## Operation
- Reset synchronizer: a SYNC_STAGES-deep flop chain, async-cleared by I_rst_n, shifts in 1, giving rst_sync_n.
- GSRI synchronizer: a SYNC_STAGES-deep flop chain, async-cleared to 0 (asserted) by I_rst_n, giving gsri_sync.
- FSM, async-reset by I_rst_n to RESET:
  - RESET: go to FILTER when rst_sync_n=1 and gsri_sync=1; counter is loaded to 1.
  - FILTER: if gsri_sync=0, go to RESET. Otherwise, when the counter equals FILTER_CYCLES, go to HOLD and clear the counter. Otherwise increment the counter.
  - HOLD: if gsri_sync=0, go to RESET. After HOLD_CYCLES clocks in HOLD, go to RUN.
  - RUN: if gsri_sync=0, go to RESET and increment O_gsr_cnt (saturating).
- O_gsr_n is a registered output, equal to 1 exactly while state=RUN. It is never combinationally derived from GSRI.
- Values while I_rst_n=0 (asynchronous): O_gsr_n=0, O_gsr=1, O_release=0, O_state=0, O_gsr_cnt=0, all synchronizer flops 0.
- Counter width: clog2 of max(FILTER_CYCLES, HOLD_CYCLES) + 1.

## Timing
- I_rst_n falling: O_gsr_n falls immediately, asynchronously, with no clock required.
- I_rst_n rising before edge 1, with GSRI=1 throughout:
  - RESET→FILTER on edge SYNC_STAGES+1.
  - FILTER→HOLD on edge SYNC_STAGES+1+FILTER_CYCLES.
  - HOLD→RUN and O_gsr_n=1 on edge SYNC_STAGES+1+FILTER_CYCLES+HOLD_CYCLES. With defaults this is edge 23.
  - O_release is high for the cycle following that edge only.
- GSRI falling while in RUN: O_gsr_n falls on edge SYNC_STAGES+1 after the fall (edge 3 by default). O_gsr_cnt increments on the same edge.
- GSRI low pulse shorter than one clock period: may be missed. A pulse of ≥ SYNC_STAGES+1 clocks is guaranteed to cause a reset.
- GSRI glitch low during FILTER or HOLD: return to RESET; the full FILTER+HOLD sequence restarts once GSRI is stable high.
- I_rst_n asserted mid-sequence, in any state: immediate return to RESET values, including O_gsr_cnt=0.
- Simultaneous rst_sync_n rise and gsri_sync=0: remain in RESET.
- GSRI stuck low: O_gsr_n stays 0 indefinitely.

## Structure
- Shared package holds state encodings (ST_RESET=2'd0, ST_FILTER=2'd1, ST_HOLD=2'd2, ST_RUN=2'd3) and the default parameter values.
- One sub-module, gsr_sync: a parameterized N-stage synchronizer with async clear. It is instantiated twice, for the reset release and for GSRI.
- FSM, counters and output registers live in the top module.

## Test plan
- I_rst_n low for 2 clocks, then high with GSRI=1 (defaults) -> O_gsr_n=0 through edge 22; 1 from edge 23; O_release high one cycle; O_state sequence 0,1,2,3.
- In RUN, drive GSRI low for 5 clocks -> O_gsr_n=0 at edge 3 after the fall; O_gsr_cnt=1; full 23-edge release after GSRI returns high.
- During FILTER, pulse GSRI low for 4 clocks -> O_state returns to 0, O_gsr_n never rises early, and the restart timing is again 3+4+16 edges.
- Assert I_rst_n low asynchronously mid-clock in RUN -> O_gsr_n=0, O_state=0 and O_gsr_cnt=0 before the next clock edge.
- Issue 300 GSRI reset events -> O_gsr_cnt saturates at 255.
- Hold GSRI=1'b1 constantly, with GSRI tied high, and run 35 ms at 500 kHz -> a single release at edge 23, O_gsr_n stays 1 with no further transitions, O_gsr_cnt=0.
